// File: rtl/seq_input_checker.sv
// Player key-sequence checker for the memory game.
// Snapshots a round's answer, compares keys, reports one verdict.
module seq_input_checker #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TO_W           = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] answer_seq,
  input  logic [3:0]  difficulty_k,
  input  logic        key_valid,
  input  logic [3:0]  key_val,
  output logic        busy,
  output logic [3:0]  cur_idx,
  output logic        result_valid,
  output logic        result_pass,
  output logic [1:0]  fail_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] K_MAX = 4'd8;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_WRONG = 2'd1;
  localparam logic [1:0] C_TOUT = 2'd2;
  localparam logic [1:0] C_ILLEGAL = 2'd3;

  state_e state_q, state_d;

  logic [31:0]     seq_q, seq_d;
  logic [3:0]      k_q, k_d;
  logic [3:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            pass_q, pass_d;
  logic [1:0]      code_q, code_d;

  logic [3:0]      k_clamp;
  logic [3:0]      exp_val;
  logic [3:0]      idx_inc;
  logic [TO_W-1:0] to_inc;
  logic            to_hit;
  logic            key_bad;
  logic            key_wrong;
  logic            key_hit;
  logic            key_last;

  // Key classification and counter helpers for the current cycle.
  always_comb begin
    k_clamp = (difficulty_k > K_MAX) ? K_MAX : difficulty_k;
    exp_val = seq_q[{idx_q[2:0], 2'b00} +: 4];
    idx_inc = idx_q + 4'd1;
    to_inc = to_q + {{(TO_W-1){1'b0}}, 1'b1};
    to_hit = (to_inc == TO_LAST);
    key_bad = (key_val == 4'd0) || (key_val > K_MAX);
    key_wrong = !key_bad && (key_val != exp_val);
    key_hit = !key_bad && (key_val == exp_val);
    key_last = (idx_q == (k_q - 4'd1));
  end

  // Round control: next state, sequence snapshot and verdict.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    k_d     = k_q;
    idx_d   = idx_q;
    to_d    = to_q;
    pass_d  = pass_q;
    code_d  = code_q;

    if (abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      code_d  = C_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            seq_d  = answer_seq;
            k_d    = k_clamp;
            idx_d  = 4'd0;
            to_d   = '0;
            pass_d = 1'b0;
            code_d = C_NONE;
            if (k_clamp == 4'd0) begin
              state_d = S_DONE;
              pass_d  = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (key_valid) begin
            to_d = '0;
            unique case (1'b1)
              key_bad: begin
                code_d  = C_ILLEGAL;
                pass_d  = 1'b0;
                state_d = S_DONE;
              end
              key_wrong: begin
                code_d  = C_WRONG;
                pass_d  = 1'b0;
                state_d = S_DONE;
              end
              key_hit && key_last: begin
                idx_d   = idx_inc;
                pass_d  = 1'b1;
                code_d  = C_NONE;
                state_d = S_DONE;
              end
              default: begin
                idx_d = idx_inc;
              end
            endcase
          end else if (to_hit) begin
            code_d  = C_TOUT;
            pass_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            to_d = to_inc;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      pass_q  <= 1'b0;
      code_q  <= C_NONE;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
    end
  end

  assign busy         = (state_q == S_WAIT);
  assign result_valid = (state_q == S_DONE);
  assign cur_idx      = idx_q;
  assign result_pass  = pass_q;
  assign fail_code    = code_q;

endmodule

// File: tb/tb_seq_input_checker.sv
// Bench for seq_input_checker: table rounds plus corner sequences.
// Verdicts are predicted into a queue and matched on result_valid.
module tb_seq_input_checker;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] answer_seq;
  logic [3:0]  difficulty_k;
  logic        key_valid;
  logic [3:0]  key_val;
  logic        busy;
  logic [3:0]  cur_idx;
  logic        result_valid;
  logic        result_pass;
  logic [1:0]  fail_code;

  seq_input_checker #(
    .TIMEOUT_CYCLES(TO),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .answer_seq(answer_seq),
    .difficulty_k(difficulty_k),
    .key_valid(key_valid),
    .key_val(key_val),
    .busy(busy),
    .cur_idx(cur_idx),
    .result_valid(result_valid),
    .result_pass(result_pass),
    .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seq;
    logic [3:0]  k;
    logic [31:0] keys;
    int          n;
    logic        pass;
    logic [1:0]  code;
    logic [3:0]  idx;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [1:0] code;
    logic [3:0] idx;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  // Match every verdict pulse against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_verdict: got valid=1 required 0 (cyc %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("verdict_cyc", cyc, e.cyc);
        chk("verdict_pass", {31'd0, result_pass}, {31'd0, e.pass});
        chk("verdict_code", {30'd0, fail_code}, {30'd0, e.code});
        chk("verdict_idx", {28'd0, cur_idx}, {28'd0, e.idx});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(int dly, logic p, logic [1:0] c,
                          logic [3:0] i);
    exp_t e;
    e.cyc = cyc + dly;
    e.pass = p;
    e.code = c;
    e.idx = i;
    sb.push_back(e);
  endtask

  task automatic do_start(logic [31:0] s, logic [3:0] k);
    answer_seq = s;
    difficulty_k = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(logic [3:0] v);
    key_val = v;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  vec_t tv[7];

  initial begin
    vec_t v;
    logic [3:0] kv;

    tv[0] = '{32'h0000_4321, 4'd4, 32'h0000_4321, 4,
              1'b1, 2'd0, 4'd4};
    tv[1] = '{32'h0000_4321, 4'd4, 32'h0000_0521, 3,
              1'b0, 2'd1, 4'd2};
    tv[2] = '{32'h8765_4321, 4'd12, 32'h8765_4321, 8,
              1'b1, 2'd0, 4'd8};
    tv[3] = '{32'h0000_4321, 4'd4, 32'h0000_0000, 1,
              1'b0, 2'd3, 4'd0};
    tv[4] = '{32'h0000_4321, 4'd0, 32'h0000_0001, 0,
              1'b1, 2'd0, 4'd0};
    tv[5] = '{32'h0000_4321, 4'd2, 32'h0000_0091, 2,
              1'b0, 2'd3, 4'd1};
    tv[6] = '{32'h0000_0068, 4'd2, 32'h0000_0068, 2,
              1'b1, 2'd0, 4'd2};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    answer_seq = '0;
    difficulty_k = '0;
    key_valid = 1'b0;
    key_val = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, result_valid}, 0);
    chk("rst_idx", {28'd0, cur_idx}, 0);
    chk("rst_code", {30'd0, fail_code}, 0);
    chk("rst_pass", {31'd0, result_pass}, 0);

    for (int r = 0; r < 7; r++) begin
      v = tv[r];
      if (v.n == 0) expect_v(1, v.pass, v.code, v.idx);
      do_start(v.seq, v.k);
      chk("busy_after_start", {31'd0, busy},
          (v.n != 0) ? 32'd1 : 32'd0);
      for (int i = 0; i < v.n; i++) begin
        kv = v.keys[4*i +: 4];
        if (i == v.n - 1) expect_v(1, v.pass, v.code, v.idx);
        press(kv);
        if (i != v.n - 1)
          chk("idx_step", {28'd0, cur_idx}, i + 1);
        tick();
        tick();
      end
      tick();
      chk("pending_row", sb.size(), 0);
      chk("held_pass", {31'd0, result_pass}, {31'd0, v.pass});
      chk("held_code", {30'd0, fail_code}, {30'd0, v.code});
      chk("idle_busy", {31'd0, busy}, 0);
      press(v.keys[3:0]);
      tick();
      chk("held_after_key", {30'd0, fail_code}, {30'd0, v.code});
      chk("idx_after_key", {28'd0, cur_idx}, {28'd0, v.idx});
    end

    // Timeout after one accepted key.
    do_start(32'h0000_4321, 4'd3);
    press(4'd1);
    expect_v(TO - 1, 1'b0, 2'd2, 4'd1);
    repeat (TO + 5) tick();
    chk("pending_tout", sb.size(), 0);

    // Timeout with no key at all after start.
    do_start(32'h0000_4321, 4'd3);
    expect_v(TO - 1, 1'b0, 2'd2, 4'd0);
    repeat (TO + 5) tick();
    chk("pending_tout0", sb.size(), 0);

    // Key arriving on the timeout cycle wins and restarts the count.
    do_start(32'h0000_4321, 4'd3);
    press(4'd1);
    repeat (TO - 2) tick();
    press(4'd2);
    chk("race_idx", {28'd0, cur_idx}, 2);
    repeat (10) tick();
    chk("race_busy", {31'd0, busy}, 1);
    expect_v(1, 1'b1, 2'd0, 4'd3);
    press(4'd3);
    tick();
    chk("pending_race", sb.size(), 0);

    // Abort mid-round: no verdict.
    do_start(32'h0000_4321, 4'd4);
    press(4'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_pass", {31'd0, result_pass}, 0);
    chk("abort_code", {30'd0, fail_code}, 0);
    repeat (3) tick();

    // Abort beats a simultaneous final key.
    do_start(32'h0000_4321, 4'd1);
    key_val = 4'd1;
    key_valid = 1'b1;
    abort = 1'b1;
    tick();
    key_valid = 1'b0;
    abort = 1'b0;
    tick();
    chk("abort_key_busy", {31'd0, busy}, 0);

    // Abort clears a held pass; abort beats start.
    expect_v(1, 1'b1, 2'd0, 4'd0);
    do_start(32'h0, 4'd0);
    tick();
    chk("k0_pass_held", {31'd0, result_pass}, 1);
    abort = 1'b1;
    start = 1'b1;
    difficulty_k = 4'd3;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_clear_pass", {31'd0, result_pass}, 0);
    chk("abort_over_start", {31'd0, busy}, 0);
    chk("pending_abort", sb.size(), 0);

    // Start and answer changes while busy are ignored.
    do_start(32'h0000_4321, 4'd2);
    press(4'd1);
    answer_seq = 32'h8888_8888;
    difficulty_k = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 1);
    chk("ign_idx", {28'd0, cur_idx}, 1);
    expect_v(1, 1'b1, 2'd0, 4'd2);
    press(4'd2);
    tick();
    chk("pending_ign", sb.size(), 0);

    // Back-to-back: start in the IDLE cycle right after DONE.
    expect_v(1, 1'b1, 2'd0, 4'd0);
    do_start(32'h0, 4'd0);
    tick();
    do_start(32'h0000_4321, 4'd1);
    chk("b2b_busy", {31'd0, busy}, 1);
    expect_v(1, 1'b1, 2'd0, 4'd1);
    press(4'd1);
    tick();
    chk("pending_b2b", sb.size(), 0);

    // Reset mid-round discards the round.
    do_start(32'h0000_4321, 4'd4);
    press(4'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_idx", {28'd0, cur_idx}, 0);
    chk("mrst_pass", {31'd0, result_pass}, 0);
    chk("mrst_code", {30'd0, fail_code}, 0);
    press(4'd2);
    repeat (3) tick();
    chk("pending_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_input_checker.md
Name: seq_input_checker

Overview:
Downstream consumer of the random sequence generator's answer_seq/seq_ready. Once the game controller starts a round, it snapshots the answer sequence and difficulty. It then compares each player key press, one nibble at a time, against the stored sequence. It reports a single pass/fail verdict with a failure cause, and enforces a per-key timeout.

Parameters:
TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between round start/accepted key and next key before timeout fail (must be >= 2)
TO_W, 26, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse from game controller; begins a round (honoured only in IDLE)
abort  input  1  level; forces return to IDLE with no verdict
answer_seq  input  32  packed sequence, element i in bits [4i+3:4i], values 1..8
difficulty_k  input  4  number of elements in the round
key_valid  input  1  single-cycle pulse, one per debounced key press
key_val  input  4  pressed key value, valid with key_valid
busy  output  1  high in WAIT_KEY
cur_idx  output  4  index of next expected element (0..8)
result_valid  output  1  one-cycle pulse carrying verdict
result_pass  output  1  1 = all elements matched; valid with result_valid, held until next start
fail_code  output  2  0 none, 1 wrong key, 2 timeout, 3 illegal key value; held like result_pass

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all outputs 0; internal seq/k/timeout registers 0.
  - Reset mid-round discards the round; no verdict is issued.
- States: IDLE, WAIT_KEY, DONE (2-bit encoding).
- IDLE:
  - On start=1 (and abort=0), latch seq_r<=answer_seq and k_r<=min(difficulty_k,8).
  - Also clear cur_idx, timeout counter, result_pass and fail_code.
  - If the clamped k is 0: go to DONE with pass=1, code=0.
  - Otherwise go to WAIT_KEY.
  - key_valid in IDLE is ignored.
- WAIT_KEY (busy=1):
  - Expected value exp = seq_r[4*cur_idx +: 4].
  - On key_valid, the key is checked in the same cycle:
    - key_val==0 or key_val>8: code=3, pass=0, go to DONE.
    - Otherwise, key_val!=exp: code=1, pass=0, go to DONE.
    - Otherwise, if cur_idx==k_r-1: pass=1, code=0, go to DONE.
    - Otherwise: cur_idx+=1, timeout counter cleared, stay in WAIT_KEY.
  - With no key_valid, the timeout counter increments. When it equals TIMEOUT_CYCLES-1: code=2, pass=0, go to DONE.
  - If key_valid and the timeout condition occur in the same cycle, key_valid wins (the key is evaluated and the counter cleared).
  - start while in WAIT_KEY is ignored; sequence and k stay latched even if answer_seq or difficulty_k change.
- DONE:
  - result_valid=1 for exactly this one cycle; busy=0; next state IDLE.
  - result_pass and fail_code stay stable until the next accepted start.
  - cur_idx holds its final value: k_r on pass, failing index on fail.
- Latency: a final key accepted at edge t gives result_valid high during the cycle after t, for one cycle.
- abort=1 in any state → IDLE at the next edge:
  - no result_valid;
  - result_pass and fail_code cleared;
  - abort has priority over start, key_valid and timeout.
- Back-to-back: start may be accepted in the IDLE cycle immediately following DONE.
- All compares are 4-bit unsigned; cur_idx never exceeds 8.

Test Plan:
- Reset check: rst=1 for 2 cycles → busy=0, result_valid=0, cur_idx=0, fail_code=0.
- Full pass (TIMEOUT_CYCLES=20):
  - Stimulus: answer_seq=32'h0000_4321, k=4, start, then keys 1,2,3,4 spaced 3 cycles apart.
  - Response: cur_idx steps 0→4; result_valid pulses once, the cycle after the 4th key; result_pass=1, fail_code=0.
- Wrong key: same seq, keys 1,2,5 → result_valid the cycle after the 5; pass=0, fail_code=1, cur_idx=2. A 4th key is ignored.
- Timeout and race:
  - Stimulus: k=3, one correct key, then no keys.
  - Response: result_valid exactly 19 cycles after the last accepted key, with code=2.
  - Race variant: a correct key on the 19th cycle is accepted, the counter restarts, and no timeout is reported.
- Edge k values and illegal key:
  - k=0 + start → result_valid the next cycle, pass=1.
  - k=12 with seq=32'h8765_4321 → 8 keys required; pass after 8.
  - key_val=0 → code=3.
- Abort/ignore:
  - abort mid-round → IDLE with no result_valid.
  - start while busy, or answer_seq changing mid-round → no effect on the latched sequence.
  - Reset asserted mid-round → outputs 0, no verdict.
